// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one cipher round per clock over a shared
// SubBytes/ShiftRows/MixColumns/AddRoundKey datapath with on-the-fly key expansion.
module aes128_round_ctrl #(
    parameter int NR      = 10,
    parameter int STATE_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_text,
    input  logic [STATE_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_text,
    output logic               busy,
    output logic [3:0]         round_idx
);

    if (STATE_W != 128) begin : g_bad_width
        $error("aes128_round_ctrl: STATE_W must be 128");
    end
    if (NR < 1 || NR > 15) begin : g_bad_nr
        $error("aes128_round_ctrl: NR must be in 1..15 to fit round_idx");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAST_FULL = 4'(NR - 1);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lut(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_lut(w[31:24]), sbox_lut(w[23:16]), sbox_lut(w[15:8]), sbox_lut(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox_lut(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; i = row + 4*column.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [1:0]   fsm;
    logic [127:0] state_q;
    logic [127:0] rk;
    logic [7:0]   rcon;

    logic [127:0] sb_sr;
    logic [127:0] next_key;
    logic [127:0] round_out;
    logic [127:0] final_out;

    assign sb_sr     = shift_rows(sub_bytes(state_q));
    assign next_key  = expand_key(rk, rcon);
    assign round_out = mix_columns(sb_sr) ^ next_key;
    assign final_out = sb_sr ^ next_key;

    assign in_ready  = (fsm == S_IDLE);
    assign out_valid = (fsm == S_DONE);
    assign busy      = (fsm == S_ROUND) || (fsm == S_FINAL);

    // NOTE: every register here is written with <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_IDLE;
            state_q   <= '0;
            rk        <= '0;
            rcon      <= 8'h01;
            round_idx <= '0;
            out_text  <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q   <= in_text ^ in_key;
                        rk        <= in_key;
                        rcon      <= 8'h01;
                        round_idx <= 4'd1;
                        fsm       <= (NR == 1) ? S_FINAL : S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q   <= round_out;
                    rk        <= next_key;
                    rcon      <= xtime(rcon);
                    round_idx <= round_idx + 4'd1;
                    if (round_idx == LAST_FULL) begin
                        fsm <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    state_q   <= final_out;
                    rk        <= next_key;
                    out_text  <= final_out;
                    round_idx <= '0;
                    fsm       <= S_DONE;
                end
                S_DONE: begin
                    // Result is held until the consumer takes it; in_valid is ignored here.
                    if (out_ready) begin
                        fsm <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: FIPS-197 vectors, handshakes, reset abort,
// and random blocks against a byte-array AES-128 model with an algebraically derived S-box.
module tb_aes128_round_ctrl;

    localparam int NR = 10;

    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         busy;
    logic [3:0]   round_idx;

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox_t [256];

    aes128_round_ctrl #(.NR(NR), .STATE_W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from the GF(2^8) multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [4*(NR+1)];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  coef;
        logic [7:0]  acc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 4*(NR+1); i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < NR) begin
                for (int i = 0; i < 16; i++) t[i] = s[i];
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) begin
                            case ((k - r + 4) % 4)
                                0:       coef = 8'h02;
                                1:       coef = 8'h03;
                                default: coef = 8'h01;
                            endcase
                            acc = acc ^ gf_mul(coef, t[k + 4*c]);
                        end
                        s[r + 4*c] = acc;
                    end
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int hold,
                             output logic [127:0] ct, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        in_text  = pt;
        in_key   = key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        ct = out_text;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] held;
        logic [127:0] pre_text;
        logic [127:0] outs [2];
        int           acc_cyc [2];
        int           lat;
        int           n;
        int           busy_cnt;
        int           acc_n;
        int           out_n;
        int           pulses;
        logic         pre_ready;
        logic         pre_valid;

        build_sbox();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_text   = '0;
        in_key    = '0;
        tick();
        tick();

        // Reset values.
        check("rst_in_ready",  128'(in_ready),  128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_round_idx", 128'(round_idx), 128'd0);
        check("rst_out_text",  out_text,        128'd0);
        rst = 1'b0;
        tick();

        // App.B with latency, busy length and round-1 key probe, then back-pressure.
        in_text  = PT1;
        in_key   = K1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_round_idx", 128'(round_idx), 128'd1);
        busy_cnt = busy ? 1 : 0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
            if (busy) busy_cnt++;
            if (n == 1) check("rk_round1", dut.rk, RK1);
        end
        check("appb_latency", 128'(n), 128'(NR));
        check("appb_busy_cycles", 128'(busy_cnt), 128'(NR));
        check("appb_out_text", out_text, CT1);
        check("appb_model", out_text, model_encrypt(PT1, K1));
        held = out_text;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_text", out_text, held);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);

        // App.C.1.
        run_block(PT2, K2, 0, ct, lat);
        check("appc_out_text", ct, CT2);
        check("appc_latency", 128'(lat), 128'(NR));

        // out_ready high while idle has no effect.
        out_ready = 1'b1;
        tick();
        tick();
        check("idle_out_ready_valid", 128'(out_valid), 128'd0);
        check("idle_out_ready_in_ready", 128'(in_ready), 128'd1);

        // Back-to-back with in_valid held high and out_ready high.
        in_text  = PT1;
        in_key   = K1;
        in_valid = 1'b1;
        acc_n = 0;
        out_n = 0;
        for (int k = 0; k < 80 && out_n < 2; k++) begin
            pre_ready = in_ready;
            pre_valid = out_valid;
            pre_text  = out_text;
            tick();
            if (pre_ready && in_valid && acc_n < 2) begin
                acc_cyc[acc_n] = k;
                acc_n++;
                if (acc_n == 1) begin
                    in_text = PT2;
                    in_key  = K2;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (pre_valid) begin
                outs[out_n] = pre_text;
                out_n++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accepts", 128'(acc_n), 128'd2);
        check("b2b_outputs", 128'(out_n), 128'd2);
        check("b2b_accept_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NR + 2));
        check("b2b_first", outs[0], CT1);
        check("b2b_second", outs[1], CT2);
        tick();

        // Reset in the middle of a block.
        in_text  = PT1;
        in_key   = K1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd5 && n < 40) begin tick(); n++; end
        check("abort_reached_round5", 128'(round_idx), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_round_idx", 128'(round_idx), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        check("abort_no_pulse", 128'(pulses), 128'd0);
        run_block(PT2, K2, 1, ct, lat);
        check("abort_then_appc", ct, CT2);

        // Random blocks against the model.
        for (int i = 0; i < 8; i++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            run_block(pt, key, int'($urandom_range(0, 3)), ct, lat);
            check("rand_out_text", ct, model_encrypt(pt, key));
            check("rand_latency", 128'(lat), 128'(NR));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
